// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: frame constants and receiver state encoding shared by the serializer and serial_frame_rx.
package serial_frame_pkg;
    typedef enum logic [1:0] {RECOVER, IDLE, DATA, STOP} state_e;
    localparam int DATA_BITS_DEFAULT = 8;
    localparam int FRAME_BITS = DATA_BITS_DEFAULT + 2;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
endpackage

// File: rtl/sipo_shift.sv
// sipo_shift: serial-in/parallel-out register; first bit shifted in ends up at bit 0 after W shifts.
module sipo_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] shreg_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shreg_q <= '0;
        else if (clr_i) shreg_q <= '0;
        else if (en_i) shreg_q <= {d_i, shreg_q[W-1:1]};
    end
    assign q_o = shreg_q;
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: 8N1-style frame receiver with one-entry valid/ready holding register.
// Optional saturating error counter enabled by SERIAL_FRAME_RX_ERR_CNT_EN.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_BITS-1:0] rx_data_q, shift_q;
    logic                 rx_valid_q, frame_err_q, overrun_q;
    logic                 shift_en, shift_clr, last_bit, good_stop;

    assign shift_en  = state_q == DATA;
    assign shift_clr = state_q == IDLE && serial_in == START_LEVEL;
    assign last_bit  = cnt_q == CNT_W'(DATA_BITS - 1);
    assign good_stop = state_q == STOP && serial_in == STOP_LEVEL;

    sipo_shift #(.W(DATA_BITS)) u_sipo (
        .clk   (clk),
        .rst   (reset),
        .clr_i (shift_clr),
        .en_i  (shift_en),
        .d_i   (serial_in),
        .q_o   (shift_q)
    );

    // RECOVER waits for a high line so the serializer's post-reset zeros never look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RECOVER;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                RECOVER: if (serial_in == IDLE_LEVEL) state_q <= IDLE;
                IDLE: if (serial_in == START_LEVEL) begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                end
                DATA: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) state_q <= STOP;
                end
                STOP: if (serial_in == STOP_LEVEL) state_q <= IDLE;
                else begin
                    state_q     <= RECOVER;
                    frame_err_q <= 1'b1;
                end
                default: state_q <= RECOVER;
            endcase
            if (good_stop && (!rx_valid_q || rx_ready)) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
            end else if (good_stop) overrun_q <= 1'b1;
            else if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = state_q == DATA || state_q == STOP;

`ifdef SERIAL_FRAME_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt_q <= '0;
        else if ((frame_err_q || overrun_q) && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end
    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed plan plus randomized frames, checked against a frame-level model of the receiver.
module tb_serial_frame_rx;
    localparam int ERR_W = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             serial_in = 1'b0;
    logic             rx_ready = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_valid, frame_err, overrun, busy;
    logic [ERR_W-1:0] err_count;

    int         n_checks = 0;
    int         n_fail = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    int         exp_cnt = 0;
    logic       pend = 1'b0;

    serial_frame_rx #(.DATA_BITS(8), .ERR_CNT_W(ERR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input logic ferr, input logic ovr, input logic exp_busy);
        check("rx_valid", 32'(rx_valid), 32'(exp_valid));
        check("rx_data", 32'(rx_data), 32'(exp_data));
        check("frame_err", 32'(frame_err), 32'(ferr));
        check("overrun", 32'(overrun), 32'(ovr));
        check("busy", 32'(busy), 32'(exp_busy));
        check("err_count", 32'(err_count), 32'(exp_cnt));
    endtask

    // One clock: drive line and ready, advance the transaction model, check after the edge.
    // mode: 0 ready low, 1 ready high, 2 random, 3 ready only at stop edge, 4 ready whenever valid.
    task automatic step(input logic line, input logic stop_edge, input logic [7:0] b,
                        input logic exp_busy, input int mode);
        logic good, ferr, ovr;
        serial_in = line;
        rx_ready = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? 1'($urandom_range(0, 1)) :
                   mode == 3 ? stop_edge : exp_valid;
        good = stop_edge && line;
        ferr = stop_edge && !line;
        ovr  = good && exp_valid && !rx_ready;
`ifdef SERIAL_FRAME_RX_ERR_CNT_EN
        if (pend && exp_cnt < ERR_MAX) exp_cnt++;
`endif
        if (good && (!exp_valid || rx_ready)) begin
            exp_data  = b;
            exp_valid = 1'b1;
        end else if (!good && exp_valid && rx_ready) exp_valid = 1'b0;
        pend = ferr || ovr;
        @(posedge clk);
        #1;
        check_all(ferr, ovr, exp_busy);
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, mode);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
        for (int i = 0; i < 10; i++)
            step(i == 0 ? 1'b0 : i == 9 ? stop : b[i-1], i == 9, b, i < 9, mode);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_cnt   = 0;
        pend      = 1'b0;
    endtask

    initial begin
        logic bad, prev_bad;
        logic [7:0] b;
        // Reset held with the line low, then the serializer's post-reset zeros.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_all(1'b0, 1'b0, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1);
        idle(1, 1);
        send_frame(8'hA5, 1'b1, 1);
        idle(2, 1);
        send_frame(8'h3C, 1'b1, 4);
        send_frame(8'hFF, 1'b1, 4);
        idle(2, 4);
        send_frame(8'h5A, 1'b0, 1);
        idle(1, 1);
        send_frame(8'h81, 1'b1, 1);
        idle(2, 1);
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        idle(1, 0);
        send_frame(8'h33, 1'b1, 3);
        idle(1, 0);
        check("hold_33", 32'(rx_data), 32'h33);
        idle(1, 1);
        // Asynchronous reset during data bit 4 of 0xC3.
        for (int i = 0; i < 5; i++) step(i == 0 ? 1'b0 : 8'hC3 >> (i - 1), 1'b0, 8'hC3, 1'b1, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all(1'b0, 1'b0, 1'b0);
        serial_in = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1);
        idle(1, 1);
        send_frame(8'h0F, 1'b1, 1);
        idle(1, 1);
        // Five framing errors drive the 2-bit counter to saturation.
        for (int i = 0; i < 5; i++) begin
            send_frame(8'($urandom), 1'b0, 1);
            idle(1, 1);
        end
        idle(1, 1);
`ifdef SERIAL_FRAME_RX_ERR_CNT_EN
        check("err_sat", 32'(err_count), 32'd3);
`else
        check("err_sat", 32'(err_count), 32'd0);
`endif
        prev_bad = 1'b0;
        for (int f = 0; f < 150; f++) begin
            idle(prev_bad ? $urandom_range(1, 2) : $urandom_range(0, 2), 2);
            bad = $urandom_range(0, 9) == 0;
            b = 8'($urandom);
            send_frame(b, !bad, 2);
            prev_bad = bad;
        end
        idle(2, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Downstream neighbour of the 10-bit parallel-in/serial-out shifter. It consumes that shifter's 1-bit line, one bit per clock, on the same clock.
- Frame format: 10 bits, LSB first. Start bit = 0, then 8 data bits, then stop bit = 1.
- Idle line level is 1.
- Recovers each data byte, checks framing and presents the byte through a one-entry valid/ready holding register.

Parameters:
- DATA_BITS, 8, number of payload bits per frame; frame length is DATA_BITS+2 = 10 at default.
- ERR_CNT_W, 8, width of the optional error counter.

Ports:
- clk  in  1  rising-edge clock, shared with the serializer.
- reset  in  1  asynchronous, active-high reset.
- serial_in  in  1  serial line from the serializer; idle 1.
- rx_data  out  DATA_BITS  held payload, LSB = first data bit received.
- rx_valid  out  1  holding register contains an unread byte.
- rx_ready  in  1  consumer accepts rx_data on a clock edge where rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: good frame dropped because the holding register was full.
- busy  out  1  high in DATA and STOP states.
- err_count  out  ERR_CNT_W  error counter (see Optional Feature).

Behaviour:
- Reset (async, active-high): state = RECOVER, bit counter = 0, shift register = 0. All outputs are 0: rx_data, rx_valid, frame_err, overrun, busy, err_count.
- Reset enters RECOVER, not IDLE, because the serializer emits 0s after its own reset. The receiver must not arm until the line has been seen high.
- States:
  - RECOVER: if serial_in == 1, go to IDLE. Otherwise stay.
  - IDLE: if serial_in == 0 (start bit), go to DATA with counter = 0. Otherwise stay.
  - DATA: shift serial_in into bit [counter], LSB first, and increment counter. After DATA_BITS samples, go to STOP.
  - STOP:
    - serial_in == 1: frame good; load the holding register (rules below) and go to IDLE.
    - serial_in == 0: pulse frame_err, discard the byte, go to RECOVER.
- Timing: start bit sampled at edge N. Data bit k sampled at edge N+1+k. Stop bit sampled at edge N+9. rx_valid is high from edge N+9.
- Back-to-back frames: the next start bit may be sampled at edge N+10 with no idle gap. There is zero dead time.
- Holding register, evaluated at the STOP edge with a good frame:
  - rx_valid == 0: load the byte; rx_valid goes to 1.
  - rx_valid == 1 and rx_ready == 1 (pop this edge): load the new byte; rx_valid stays 1.
  - rx_valid == 1 and rx_ready == 0: keep the old byte, drop the new one, pulse overrun.
- Pop with no load: rx_valid goes to 0; rx_data holds its last value.
- rx_ready while rx_valid == 0 has no effect.
- frame_err and overrun are registered pulses, high exactly one cycle after the triggering edge.
- Reset mid-frame: partial byte discarded; state goes to RECOVER.
- The line has no oversampling, no glitch filtering and no clock recovery; both ends share clk.

Optional Feature:
Macro: SERIAL_FRAME_RX_ERR_CNT_EN
- Defined:
  - err_count increments on every frame_err or overrun pulse and saturates at 2^ERR_CNT_W-1.
  - If both pulses fire in one cycle, err_count increments by 1 only.
  - Cleared only by reset.
- Undefined: no counter logic is built; err_count is tied to 0.

Decomposition:
- Shared package serial_frame_pkg holds:
  - the state enum (RECOVER, IDLE, DATA, STOP);
  - DATA_BITS default 8;
  - FRAME_BITS = DATA_BITS+2;
  - IDLE_LEVEL = 1, START_LEVEL = 0, STOP_LEVEL = 1.
- The serializer also uses this package.
- One sub-module is natural: sipo_shift, a DATA_BITS serial-in/parallel-out register with a shift enable and synchronous clear. FSM, holding register and counter stay in the top level.

Test Plan:
1. Reset held with serial_in = 0 for 5 cycles, then line high 1 cycle, then frame for 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) with rx_ready = 1 -> no false frame; rx_data = 0xA5 and rx_valid = 1 from edge N+9; frame_err never set.
2. Frames 0x3C then 0xFF back-to-back with no gap; rx_ready pulsed in the cycle after each rx_valid -> two bytes delivered in order, 10 cycles apart, overrun = 0.
3. Frame 0x5A with stop bit forced to 0 -> frame_err pulses once, rx_valid stays 0, state RECOVER; next frame 0x81 after line high -> rx_data = 0x81.
4. rx_ready = 0, send 0x11 then 0x22 -> rx_data = 0x11 retained, overrun pulses at 0x22's stop edge. Then rx_ready = 1 pops at the same edge as the 0x33 stop -> rx_data = 0x33, rx_valid stays 1.
5. Assert reset during data bit 4 of frame 0xC3 -> outputs return to 0 immediately (async); the following 0x0F frame is received correctly after the line goes high.
6. With SERIAL_FRAME_RX_ERR_CNT_EN and ERR_CNT_W = 2, inject 5 framing errors -> err_count = 3 (saturated). Without the macro -> err_count = 0 throughout.
